// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among |
// | N_REQ byte producers, with inter-frame gap and BUSY watchdog.             |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int D_W     = 8,
  parameter int GAP_CYC = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*D_W-1:0]     req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [D_W-1:0]           tx_byte,
  input  logic                     tx_done,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int c_IDX_W = $clog2(N_REQ);
  localparam int c_WD_W  = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam int c_GAP_W = ($clog2(GAP_CYC + 1) > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LAUNCH = 2'd1;
  localparam logic [1:0] c_BUSY   = 2'd2;
  localparam logic [1:0] c_GAP    = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_IDX_W-1:0] r_rr_ptr;
  logic [c_IDX_W-1:0] r_grant_idx;
  logic [D_W-1:0]     r_tx_byte;
  logic [c_WD_W-1:0]  r_wdog;
  logic [c_GAP_W-1:0] r_gap;
  logic               r_done_q;
  logic               r_timeout_err;

  logic [c_IDX_W-1:0] w_win;
  logic [c_IDX_W-1:0] w_cand;
  logic               w_any;
  logic               w_done_evt;
  logic               w_wd_hit;
  logic               w_to_set;
  logic [D_W-1:0]     w_data [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_data[gi] = req_data[gi*D_W +: D_W];
  end

  function automatic logic [c_IDX_W-1:0] f_wrap(input logic [c_IDX_W-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % N_REQ;
    return c_IDX_W'(s);
  endfunction

  // Scan starts one past the last winner so every requester is reached within N_REQ grants.
  always_comb begin
    w_win  = '0;
    w_cand = '0;
    w_any  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = f_wrap(r_rr_ptr, k);
      if (!w_any && req_valid[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  // Only a rising edge completes a frame, so a level left high from the last frame is ignored.
  assign w_done_evt = tx_done & ~r_done_q;
  assign w_wd_hit   = (r_wdog == c_WD_LAST);
  assign w_to_set   = (r_state == c_BUSY) && !w_done_evt && w_wd_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (w_any) w_state_nxt = c_LAUNCH;
      c_LAUNCH: w_state_nxt = c_BUSY;
      c_BUSY:   if (w_done_evt || w_wd_hit) w_state_nxt = (GAP_CYC == 0) ? c_IDLE : c_GAP;
      c_GAP:    if (r_gap == c_GAP_LAST) w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    tx_start  = 1'b0;
    busy      = (r_state != c_IDLE);
    if (r_state == c_IDLE && w_any && rst_n) req_ready[w_win] = 1'b1;
    if (r_state == c_LAUNCH) tx_start = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr      <= c_IDX_W'(N_REQ - 1);
      r_grant_idx   <= '0;
      r_tx_byte     <= '0;
      r_wdog        <= '0;
      r_gap         <= '0;
      r_done_q      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_done_q <= tx_done;
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            r_tx_byte   <= w_data[w_win];
            r_grant_idx <= w_win;
            r_rr_ptr    <= w_win;
          end
        end
        c_LAUNCH: r_wdog <= '0;
        c_BUSY: begin
          if (w_done_evt || w_wd_hit) r_gap  <= '0;
          else                        r_wdog <= r_wdog + 1'b1;
        end
        default: begin
          if (r_gap != c_GAP_LAST) r_gap <= r_gap + 1'b1;
        end
      endcase
      if (w_to_set)     r_timeout_err <= 1'b1;
      else if (err_clr) r_timeout_err <= 1'b0;
    end
  end

  assign tx_byte     = r_tx_byte;
  assign grant_idx   = r_grant_idx;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_arbiter: directed + randomized bench for uart_tx_arbiter with  |
// | a timestamp-based transaction model of grants, frames and gaps.           |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int c_N   = 4;
  localparam int c_DW  = 8;
  localparam int c_GAP = 16;
  localparam int c_TO  = 120;
  localparam int c_FAR = 32'h7fffffff;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [c_N-1:0]      req_valid;
  logic [c_N*c_DW-1:0] req_data;
  logic [c_N-1:0]      req_ready;
  logic                tx_start;
  logic [c_DW-1:0]     tx_byte;
  logic                tx_done;
  logic [1:0]          grant_idx;
  logic                busy;
  logic                timeout_err;
  logic                err_clr;

  uart_tx_arbiter #(.N_REQ(c_N), .D_W(c_DW), .GAP_CYC(c_GAP), .TIMEOUT(c_TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_byte(tx_byte), .tx_done(tx_done),
    .grant_idx(grant_idx), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: a frame is described by its accept cycle, its completion cycle and the scan pointer.
  int        m_rr, m_accept, m_end, m_start, m_done_at, m_idx;
  logic [7:0] m_byte;
  bit        m_in_frame, m_err, m_prev_done;

  logic [c_N-1:0]      stim_valid;
  logic [c_N*c_DW-1:0] stim_data;
  logic                stim_clr, stim_done;
  int  t_mode;   // 0: pulse flen cycles after tx_start, 1: never done, 2: manual level
  bit  noise_en;
  int  flen;
  int  grant_log[$];
  int  last_grant, acc_cyc, err_cyc, idle_cyc;
  bit  seen_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int f_winner(input int rr, input logic [c_N-1:0] v);
    for (int k = 1; k <= c_N; k++)
      if (v[(rr + k) % c_N]) return (rr + k) % c_N;
    return -1;
  endfunction

  function automatic int f_onehot_idx(input logic [c_N-1:0] v);
    for (int i = 0; i < c_N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = c_N - 1; m_accept = -1; m_end = -1; m_start = -1; m_done_at = -1;
    m_idx = 0; m_byte = 8'h00; m_in_frame = 1'b0; m_err = 1'b0; m_prev_done = 1'b0;
    seen_err = 1'b0;
  endtask

  task automatic step();
    int win;
    logic [c_N-1:0] exp_rdy;
    bit bz, done_ev, set_err;
    @(negedge clk);
    req_valid = stim_valid;
    req_data  = stim_data;
    err_clr   = stim_clr;
    case (t_mode)
      0:       tx_done = (cyc == m_done_at) || (!m_in_frame && noise_en && $urandom_range(7) == 0);
      1:       tx_done = 1'b0;
      default: tx_done = stim_done;
    endcase
    #1;
    bz  = (cyc > m_accept) && (cyc < m_end);
    win = f_winner(m_rr, req_valid);
    exp_rdy = '0;
    if (!bz && win >= 0) exp_rdy[win] = 1'b1;
    check_val("req_ready",   32'(req_ready),   32'(exp_rdy));
    check_val("tx_start",    32'(tx_start),    32'(cyc == m_start));
    check_val("busy",        32'(busy),        32'(bz));
    check_val("tx_byte",     32'(tx_byte),     32'(m_byte));
    check_val("grant_idx",   32'(grant_idx),   32'(m_idx));
    check_val("timeout_err", 32'(timeout_err), 32'(m_err));
    if (req_ready != '0) begin
      last_grant = f_onehot_idx(req_ready);
      grant_log.push_back(last_grant);
      acc_cyc = cyc;
    end
    if (timeout_err && !seen_err) err_cyc = cyc;
    seen_err = timeout_err;
    done_ev = tx_done && !m_prev_done;
    set_err = 1'b0;
    if (m_in_frame && cyc >= m_accept + 2) begin
      if (done_ev) begin
        m_end = cyc + 1 + c_GAP; m_in_frame = 1'b0;
      end else if (cyc - (m_accept + 2) == c_TO - 1) begin
        set_err = 1'b1; m_end = cyc + 1 + c_GAP; m_in_frame = 1'b0;
      end
    end
    if (win >= 0 && !bz) begin
      m_rr = win; m_idx = win; m_byte = req_data[win*c_DW +: c_DW];
      m_accept = cyc; m_start = cyc + 1; m_end = c_FAR; m_in_frame = 1'b1;
      m_done_at = cyc + 1 + flen;
    end
    if (set_err)      m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    m_prev_done = tx_done;
    cyc++;
  endtask

  task automatic run_until_idle(input int limit);
    bit ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      step();
      if (!busy) begin ok = 1'b1; break; end
    end
    idle_cyc = cyc - 1;
    check_val("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic grant_wait(input logic [c_N-1:0] v, input int limit);
    int n = grant_log.size();
    bit ok = 1'b0;
    stim_valid = v;
    for (int k = 0; k < limit; k++) begin
      step();
      if (grant_log.size() > n) begin ok = 1'b1; break; end
    end
    stim_valid = '0;
    check_val("grant_seen", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; req_valid = '1; tx_done = 1'b0;
    #1;
    check_val("rst_req_ready",   32'(req_ready),   32'd0);
    check_val("rst_tx_start",    32'(tx_start),    32'd0);
    check_val("rst_busy",        32'(busy),        32'd0);
    check_val("rst_tx_byte",     32'(tx_byte),     32'd0);
    check_val("rst_grant_idx",   32'(grant_idx),   32'd0);
    check_val("rst_timeout_err", 32'(timeout_err), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; tx_done = 1'b0; err_clr = 1'b0;
    stim_valid = '0; stim_data = '0; stim_clr = 1'b0; stim_done = 1'b0;
    t_mode = 0; noise_en = 1'b0; flen = 100;
    last_grant = -1; acc_cyc = 0; err_cyc = 0; idle_cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("por_busy",        32'(busy),        32'd0);
    check_val("por_tx_byte",     32'(tx_byte),     32'd0);
    check_val("por_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, 100-cycle frame then 16-cycle gap.
    stim_data = $urandom;
    stim_data[2*c_DW +: c_DW] = 8'hA5;
    grant_wait(4'b0100, 10);
    check_val("single_grant", 32'(last_grant), 32'd2);
    step();
    check_val("single_start", 32'(tx_start),  32'd1);
    check_val("single_byte",  32'(tx_byte),   32'hA5);
    check_val("single_idx",   32'(grant_idx), 32'd2);
    run_until_idle(300);
    check_val("single_idle_at", 32'(idle_cyc - acc_cyc), 32'(1 + 100 + 1 + c_GAP));

    // Asynchronous reset in the middle of a frame.
    stim_data = $urandom;
    grant_wait(4'b0010, 10);
    repeat (5) step();
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    do_reset();

    // Fairness from reset: all four pending, 20-cycle frames.
    flen = 20;
    grant_log.delete();
    stim_valid = 4'hF;
    for (int k = 0; k < 1000 && grant_log.size() < 6; k++) step();
    stim_valid = '0;
    check_val("fair_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check_val("fair_order", 32'(grant_log[i]), 32'(i % c_N));
    run_until_idle(200);

    // Wrap-around of the scan pointer.
    grant_wait(4'b1000, 10);
    check_val("wrap_g3", 32'(last_grant), 32'd3);
    run_until_idle(200);
    grant_wait(4'b0010, 10);
    check_val("wrap_g1", 32'(last_grant), 32'd1);
    run_until_idle(200);
    grant_wait(4'b1000, 10);
    run_until_idle(200);
    grant_wait(4'b1001, 10);
    check_val("wrap_g0", 32'(last_grant), 32'd0);
    run_until_idle(200);

    // tx_done held high across frames: second frame waits for a fresh rising edge.
    t_mode = 2; stim_done = 1'b0;
    grant_wait(4'b0001, 10);
    repeat (10) step();
    stim_done = 1'b1;
    run_until_idle(200);
    grant_wait(4'b0010, 10);
    repeat (60) step();
    check_val("sticky_hold", 32'(busy), 32'd1);
    stim_done = 1'b0;
    step();
    stim_done = 1'b1;
    step();
    run_until_idle(200);
    check_val("sticky_release", 32'(idle_cyc - acc_cyc), 32'(62 + 1 + c_GAP));
    stim_done = 1'b0;

    // Watchdog: transmitter never reports done.
    t_mode = 1;
    grant_wait(4'b0100, 10);
    run_until_idle(400);
    check_val("wd_latency", 32'(err_cyc - (acc_cyc + 2)), 32'(c_TO));
    check_val("wd_gap",     32'(idle_cyc - err_cyc),      32'(c_GAP));
    check_val("wd_sticky",  32'(timeout_err),             32'd1);
    stim_clr = 1'b1;
    step();
    stim_clr = 1'b0;
    step();
    check_val("wd_clear", 32'(timeout_err), 32'd0);

    // Randomized traffic with spurious done pulses and error clears.
    t_mode = 0; noise_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      stim_valid = c_N'($urandom);
      stim_data  = $urandom;
      stim_clr   = ($urandom_range(15) == 0);
      flen       = $urandom_range(40, 1);
      step();
    end
    stim_valid = '0; stim_clr = 1'b0; noise_en = 1'b0;
    run_until_idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
